// File: rtl/st_burst_ctrl.sv
// st_burst_ctrl: button-started burst sequencer for the periodic sampling strobe ce_st.
// A synchronised BTN rising edge starts a burst of burst_r strobes spaced period_r
// clocks apart (burst_r == 0 runs until stop). Host config is accepted only in IDLE.
// Optional feature macro: BTN_DEBOUNCE_EN (adds a DB_CYCLES-clock button debouncer).
module st_burst_ctrl #(
  parameter int unsigned TCLK      = 20,
  parameter int unsigned TREP      = 200000,
  parameter int unsigned PW        = 16,
  parameter int unsigned BW        = 8,
  parameter int unsigned BURST_DEF = 8
`ifdef BTN_DEBOUNCE_EN
  ,
  parameter int unsigned DB_CYCLES = 500000
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          BTN,
  input  logic          stop,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  input  logic [BW-1:0] cfg_burst,
  output logic          ce_st,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] cnt
);

  localparam int unsigned N = TREP / TCLK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic          start_p;
  logic [PW-1:0] tact;
  logic [PW-1:0] period_r;
  logic [BW-1:0] burst_r;
  logic          tact_wrap_c;
  logic [BW-1:0] cnt_inc_c;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

  logic [DBW-1:0] db_cnt;
  logic           d;
  logic           d_prev;

  // Debounced level follows s2 only after DB_CYCLES consecutive differing clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      d      <= 1'b0;
      d_prev <= 1'b0;
    end else begin
      d_prev <= d;
      if (s2 == d) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        d      <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign start_p = d & ~d_prev;
`else
  logic s3;

  // Edge-detect delay stage behind the synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3 <= 1'b0;
    end else begin
      s3 <= s2;
    end
  end

  assign start_p = s2 & ~s3;
`endif

  assign tact_wrap_c = (tact == period_r - PW'(1));
  assign cnt_inc_c   = cnt + BW'(1);

  // Burst FSM: config capture, tact timing, strobe/count/status generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ce_st    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      tact     <= '0;
      period_r <= PW'(N);
      burst_r  <= BW'(BURST_DEF);
    end else begin
      ce_st <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            period_r <= (cfg_period < PW'(2)) ? PW'(2) : cfg_period;
            burst_r  <= cfg_burst;
          end
          if (start_p) begin
            state <= RUN;
            tact  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // stop has priority over a strobe due on the same edge
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            tact  <= '0;
          end else if (tact_wrap_c) begin
            tact  <= '0;
            ce_st <= 1'b1;
            cnt   <= cnt_inc_c;
            if ((burst_r != '0) && (cnt_inc_c == burst_r)) begin
              state <= DONE;
            end
          end else begin
            tact <= tact + PW'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_burst_ctrl.sv
// Scoreboard bench for st_burst_ctrl: the driver predicts strobe/done edges from
// start edge, period and burst length, and a monitor checks each DUT event in order.
module tb_st_burst_ctrl;

  localparam int unsigned PW = 16;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          BTN = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          ce_st;
  logic          busy;
  logic          done;
  logic [BW-1:0] cnt;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    int unsigned   at_edge;
    bit            is_done;
    logic [BW-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  // reference configuration as the host sees it
  int unsigned m_period = 10000;
  int unsigned m_burst  = 8;

  st_burst_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BTN        (BTN),
    .stop       (stop),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .cfg_burst  (cfg_burst),
    .ce_st      (ce_st),
    .busy       (busy),
    .done       (done),
    .cnt        (cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  task automatic mon_evt(input bit is_done);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk(is_done ? "unexpected_done" : "unexpected_ce_st", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(is_done), 32'(e.is_done));
      chk("event_edge", cyc, e.at_edge);
      if (!is_done) chk("strobe_cnt", 32'(cnt), 32'(e.cnt));
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ce_st !== 1'b0) mon_evt(1'b0);
        if (done !== 1'b0) mon_evt(1'b1);
      end
    end
  end

  task automatic run_txn(input bit do_cfg, input int unsigned pcfg, input int unsigned bcfg,
                         input bit use_stop_in, input int unsigned stop_off_in, input bit disturb_in);
    int unsigned e_acc, stop_edge, n_str, k, done_edge, last, end_edge;
    bit has_done, use_stop, disturb;
    ev_t e;
    use_stop = use_stop_in;
    disturb  = disturb_in;
    @(negedge clk);
    if (do_cfg) begin
      cfg_we     = 1'b1;
      cfg_period = PW'(pcfg);
      cfg_burst  = BW'(bcfg);
      @(negedge clk);
      cfg_we   = 1'b0;
      m_period = (pcfg < 2) ? 2 : pcfg;
      m_burst  = bcfg;
    end
    if (m_burst == 0 && !use_stop) use_stop = 1'b1;
    BTN   = 1'b1;
    e_acc = cyc + 3;
    stop_edge = use_stop ? e_acc + ((stop_off_in == 0) ? m_period * 4 + 1 : stop_off_in)
                         : 32'hFFFF_FFFF;
    n_str = 0;
    k = 1;
    while ((m_burst == 0 || k <= m_burst) && (e_acc + k * m_period < stop_edge)) begin
      e.at_edge = e_acc + k * m_period;
      e.is_done = 1'b0;
      e.cnt     = BW'(k);
      exp_q.push_back(e);
      n_str++;
      k++;
    end
    has_done  = (m_burst != 0) && (n_str == m_burst);
    done_edge = e_acc + m_burst * m_period + 1;
    if (has_done) begin
      e.at_edge = done_edge;
      e.is_done = 1'b1;
      e.cnt     = '0;
      exp_q.push_back(e);
    end
    last     = has_done ? done_edge : 0;
    end_edge = has_done ? done_edge : stop_edge;
    if (use_stop && stop_edge > last) last = stop_edge;
    if (end_edge <= e_acc + 8) disturb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    BTN = 1'b0;
    while (cyc < last + 3) begin
      @(negedge clk);
      if (cyc == e_acc) chk("busy_run", 32'(busy), 32'd1);
      if (use_stop && cyc == stop_edge - 1) stop = 1'b1;
      if (use_stop && cyc == stop_edge) stop = 1'b0;
      if (disturb && cyc == e_acc + 1) begin
        BTN        = 1'b1;
        cfg_we     = 1'b1;
        cfg_period = PW'(9);
        cfg_burst  = BW'(1);
      end
      if (disturb && cyc == e_acc + 2) cfg_we = 1'b0;
      if (disturb && cyc == e_acc + 3) BTN = 1'b0;
    end
    stop = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("cnt_final", 32'(cnt), 32'(BW'(n_str)));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned e_acc, pcfg, bcfg, eff_p, eff_b, stop_off;
    bit do_cfg, use_stop;
    ev_t e;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ce_st", 32'(ce_st), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // default period: first strobe at E+10000, then abort
    run_txn(1'b0, 0, 0, 1'b1, 10003, 1'b0);
    // period 4, burst 3, normal completion
    run_txn(1'b1, 4, 3, 1'b0, 0, 1'b0);
    // continuous, stop on the third strobe edge (suppressed) and just after it
    run_txn(1'b1, 5, 0, 1'b1, 15, 1'b0);
    run_txn(1'b1, 5, 0, 1'b1, 16, 1'b0);
    // BTN and cfg_we during RUN are ignored; period stays 4
    run_txn(1'b1, 4, 3, 1'b0, 0, 1'b1);
    run_txn(1'b0, 0, 0, 1'b0, 0, 1'b0);
    // period below 2 is clamped
    run_txn(1'b1, 1, 2, 1'b0, 0, 1'b0);
    run_txn(1'b1, 0, 3, 1'b0, 0, 1'b0);
    // continuous count wraps past 2^BW-1
    run_txn(1'b1, 2, 0, 1'b1, 2 * 260 + 1, 1'b0);
    // stop landing in DONE is ignored
    run_txn(1'b1, 3, 2, 1'b1, 7, 1'b0);

    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      do_cfg = ($urandom_range(0, 3) != 0);
      pcfg   = $urandom_range(0, 12);
      bcfg   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      eff_p  = do_cfg ? ((pcfg < 2) ? 2 : pcfg) : m_period;
      eff_b  = do_cfg ? bcfg : m_burst;
      use_stop = (eff_b == 0) || ($urandom_range(0, 2) == 0);
      stop_off = $urandom_range(1, eff_p * ((eff_b == 0) ? 5 : eff_b) + 3);
      run_txn(do_cfg, pcfg, bcfg, use_stop, stop_off, 1'($urandom_range(0, 1)));
    end

    // reset mid-burst: outputs clear immediately, config returns to defaults
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_period = PW'(6);
    cfg_burst  = BW'(5);
    @(negedge clk);
    cfg_we = 1'b0;
    BTN    = 1'b1;
    e_acc  = cyc + 3;
    for (int k = 1; k <= 5; k++) begin
      e.at_edge = e_acc + k * 6;
      e.is_done = 1'b0;
      e.cnt     = BW'(k);
      exp_q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    BTN = 1'b0;
    while (cyc < e_acc + 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ce_st", 32'(ce_st), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    exp_q.delete();
    m_period = 10000;
    m_burst  = 8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(1'b0, 0, 0, 1'b1, 10002, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
